// File: rtl/sdram_port_sched.sv
// sdram_port_sched: two-port round-robin burst scheduler in front of an SDRAM controller.
// One port at a time owns the controller. That port's request direction and
// address are latched when it is granted.
// Optional watchdog in WAIT: define SDRAM_SCHED_WDOG_EN to build it.
module sdram_port_sched #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned BURST_LEN   = 512,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_done,
  output logic              p1_done,
  output logic              ctl_write_trig,
  output logic              ctl_read_trig,
  output logic [ADDR_W-1:0] ctl_addr,
  input  logic              ctl_data_vld,
  input  logic              ctl_write_end,
  input  logic              ctl_read_end,
  output logic              busy,
  output logic              len_err,
  output logic              wdog_err
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GRANT = 5'b00010,
    ISSUE = 5'b00100,
    WAIT  = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t           state;
  logic             owner;
  logic             dir_wr;
  logic             rr_pref;
  logic [CNT_W-1:0] beat_cnt;
  logic             sel_c;
  logic             end_match_c;
  logic             wdog_expire_c;

  // Both requesting: take the preferred port; otherwise whichever is asking.
  assign sel_c = (p0_req & p1_req) ? rr_pref : p1_req;

  // Only the end pulse of the latched direction completes a burst.
  assign end_match_c = dir_wr ? ctl_write_end : ctl_read_end;

`ifdef SDRAM_SCHED_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            wdog_err_q;

  assign wdog_expire_c = (state == WAIT) && !end_match_c &&
                         (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
  assign wdog_err = wdog_err_q;

  // Cycles spent in WAIT; sticky error on expiry.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state == WAIT) wdog_cnt <= wdog_cnt + WD_W'(1);
      else               wdog_cnt <= '0;
      if (wdog_expire_c) wdog_err_q <= 1'b1;
    end
  end
`else
  assign wdog_expire_c = 1'b0;
  assign wdog_err      = 1'b0;
`endif

  // Scheduler FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      dir_wr         <= 1'b0;
      rr_pref        <= 1'b0;
      beat_cnt       <= '0;
      p0_gnt         <= 1'b0;
      p1_gnt         <= 1'b0;
      p0_done        <= 1'b0;
      p1_done        <= 1'b0;
      ctl_write_trig <= 1'b0;
      ctl_read_trig  <= 1'b0;
      ctl_addr       <= '0;
      busy           <= 1'b0;
      len_err        <= 1'b0;
    end else begin
      ctl_write_trig <= 1'b0;
      ctl_read_trig  <= 1'b0;
      p0_done        <= 1'b0;
      p1_done        <= 1'b0;

      if (((state == ISSUE) || (state == WAIT)) && ctl_data_vld && (beat_cnt != CNT_MAX))
        beat_cnt <= beat_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (p0_req | p1_req) begin
            owner    <= sel_c;
            dir_wr   <= sel_c ? p1_wr : p0_wr;
            ctl_addr <= sel_c ? p1_addr : p0_addr;
            p0_gnt   <= ~sel_c;
            p1_gnt   <= sel_c;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          ctl_write_trig <= dir_wr;
          ctl_read_trig  <= ~dir_wr;
          state          <= ISSUE;
        end
        ISSUE: begin
          if (end_match_c) begin
            p0_done <= ~owner;
            p1_done <= owner;
            state   <= DONE;
          end else begin
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (end_match_c || wdog_expire_c) begin
            p0_done <= ~owner;
            p1_done <= owner;
            state   <= DONE;
          end
        end
        DONE: begin
          if (beat_cnt != CNT_W'(BURST_LEN)) len_err <= 1'b1;
          rr_pref  <= ~owner;
          beat_cnt <= '0;
          p0_gnt   <= 1'b0;
          p1_gnt   <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          p0_gnt <= 1'b0;
          p1_gnt <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched with hand-computed expectations.
module tb_sdram_port_sched;

  logic        sysclk_100M = 1'b0;
  logic        rst_n = 1'b1;
  logic        p0_req = 1'b0, p0_wr = 1'b0, p1_req = 1'b0, p1_wr = 1'b0;
  logic [23:0] p0_addr = '0, p1_addr = '0;
  logic        ctl_data_vld = 1'b0, ctl_write_end = 1'b0, ctl_read_end = 1'b0;
  logic        p0_gnt, p1_gnt, p0_done, p1_done;
  logic        ctl_write_trig, ctl_read_trig, busy, len_err, wdog_err;
  logic [23:0] ctl_addr;

  int checks = 0;
  int errors = 0;

  always #5 sysclk_100M = ~sysclk_100M;

  sdram_port_sched #(.ADDR_W(24), .BURST_LEN(512), .WDOG_CYCLES(4096)) u_dut (
    .sysclk_100M(sysclk_100M), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .ctl_write_trig(ctl_write_trig), .ctl_read_trig(ctl_read_trig), .ctl_addr(ctl_addr),
    .ctl_data_vld(ctl_data_vld), .ctl_write_end(ctl_write_end), .ctl_read_end(ctl_read_end),
    .busy(busy), .len_err(len_err), .wdog_err(wdog_err)
  );

`ifdef SDRAM_SCHED_WDOG_EN
  logic        wd_p0_gnt, wd_p1_gnt, wd_p0_done, wd_p1_done;
  logic        wd_wtrig, wd_rtrig, wd_busy, wd_len_err, wd_wdog_err;
  logic [23:0] wd_addr;

  sdram_port_sched #(.ADDR_W(24), .BURST_LEN(512), .WDOG_CYCLES(64)) u_wd (
    .sysclk_100M(sysclk_100M), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr),
    .p0_gnt(wd_p0_gnt), .p1_gnt(wd_p1_gnt), .p0_done(wd_p0_done), .p1_done(wd_p1_done),
    .ctl_write_trig(wd_wtrig), .ctl_read_trig(wd_rtrig), .ctl_addr(wd_addr),
    .ctl_data_vld(ctl_data_vld), .ctl_write_end(ctl_write_end), .ctl_read_end(ctl_read_end),
    .busy(wd_busy), .len_err(wd_len_err), .wdog_err(wd_wdog_err)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk_100M);
    #1;
  endtask

  task automatic set_req(input int p, input logic req, input logic wr, input logic [23:0] addr);
    if (p == 0) begin p0_req = req; p0_wr = wr; p0_addr = addr; end
    else        begin p1_req = req; p1_wr = wr; p1_addr = addr; end
  endtask

  function automatic logic [8:0] outs();
    return {p0_gnt, p1_gnt, p0_done, p1_done, ctl_write_trig, ctl_read_trig,
            busy, len_err, wdog_err};
  endfunction

  // Full burst from an IDLE cycle; optional wrong-direction end pulse 10 cycles early.
  task automatic run_burst(input int p, input logic wr, input logic [23:0] addr,
                           input int beats, input logic distract, input logic exp_len);
    int seen;
    set_req(p, 1'b1, wr, addr);
    tick();
    check_eq("gnt_t1", {30'd0, p1_gnt, p0_gnt}, (p == 0) ? 32'd1 : 32'd2);
    check_eq("addr_t1", {8'd0, ctl_addr}, {8'd0, addr});
    check_eq("trig_t1", {30'd0, ctl_write_trig, ctl_read_trig}, 32'd0);
    set_req(p, 1'b1, ~wr, ~addr);
    tick();
    check_eq("trig_t2", {30'd0, ctl_write_trig, ctl_read_trig}, wr ? 32'd2 : 32'd1);
    check_eq("addr_hold", {8'd0, ctl_addr}, {8'd0, addr});
    repeat (beats) begin
      ctl_data_vld = 1'b1;
      tick();
    end
    ctl_data_vld = 1'b0;
    if (distract) begin
      if (wr) ctl_read_end = 1'b1; else ctl_write_end = 1'b1;
      tick();
      ctl_read_end = 1'b0;
      ctl_write_end = 1'b0;
      seen = 0;
      repeat (9) begin
        if (p0_done || p1_done || !busy) seen++;
        tick();
      end
      check_eq("no_early_done", seen, 0);
    end
    if (wr) ctl_write_end = 1'b1; else ctl_read_end = 1'b1;
    tick();
    ctl_write_end = 1'b0;
    ctl_read_end  = 1'b0;
    check_eq("done", {30'd0, p1_done, p0_done}, (p == 0) ? 32'd1 : 32'd2);
    check_eq("gnt_in_done", {30'd0, p1_gnt, p0_gnt}, (p == 0) ? 32'd1 : 32'd2);
    set_req(p, 1'b0, 1'b0, '0);
    tick();
    check_eq("back_idle", {27'd0, busy, p1_gnt, p0_gnt, p1_done, p0_done}, 32'd0);
    check_eq("len_err", {31'd0, len_err}, {31'd0, exp_len});
  endtask

  initial begin
    int exp_p;
    int seen;
    int wd_n;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_outs", {23'd0, outs()}, 32'd0);
    check_eq("rst_addr", {8'd0, ctl_addr}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Port 0 write, full-length burst
    run_burst(0, 1'b1, 24'h000200, 512, 1'b0, 1'b0);

    // Read burst ignores a stray write_end
    run_burst(0, 1'b0, 24'h0A0B0C, 512, 1'b1, 1'b0);

    // Port 1 short read sets sticky len_err
    run_burst(1, 1'b0, 24'h345678, 500, 1'b0, 1'b1);
    tick();
    check_eq("len_err_sticky", {31'd0, len_err}, 32'd1);

    // Simultaneous held requests alternate 0,1,0,1
    p0_req = 1'b1; p0_wr = 1'b1; p0_addr = 24'h000100;
    p1_req = 1'b1; p1_wr = 1'b1; p1_addr = 24'h000200;
    for (int k = 0; k < 4; k++) begin
      exp_p = k % 2;
      tick();
      check_eq("rr_gnt", {30'd0, p1_gnt, p0_gnt}, (exp_p == 0) ? 32'd1 : 32'd2);
      check_eq("rr_addr", {8'd0, ctl_addr}, (exp_p == 0) ? 32'h100 : 32'h200);
      tick();
      ctl_write_end = 1'b1;
      tick();
      ctl_write_end = 1'b0;
      check_eq("rr_done", {30'd0, p1_done, p0_done}, (exp_p == 0) ? 32'd1 : 32'd2);
      tick();
      check_eq("rr_idle_gap", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    check_eq("len_err_still", {31'd0, len_err}, 32'd1);
    tick();

    // Missing end pulse: watchdog build aborts at 64 WAIT cycles, main instance waits
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    set_req(1, 1'b1, 1'b1, 24'h00ABCD);
    repeat (3) tick();
    seen = 0;
    wd_n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (p0_done || p1_done) seen++;
`ifdef SDRAM_SCHED_WDOG_EN
      if (wd_p1_done && wd_n == 0) wd_n = i;
`endif
    end
    check_eq("wait_no_done", seen, 0);
    check_eq("wait_busy_gnt", {30'd0, busy, p1_gnt}, 32'd3);
    check_eq("wait_wdog_err", {31'd0, wdog_err}, 32'd0);
`ifdef SDRAM_SCHED_WDOG_EN
    check_eq("wdog_done_at", wd_n, 64);
    check_eq("wdog_err_set", {31'd0, wd_wdog_err}, 32'd1);
`endif

    // Reset while waiting: outputs clear at once, no done, clean restart
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", {23'd0, outs()}, 32'd0);
    check_eq("midrst_addr", {8'd0, ctl_addr}, 32'd0);
    seen = 0;
    repeat (3) begin
      tick();
      if (p0_done || p1_done) seen++;
    end
    check_eq("midrst_no_done", seen, 0);
    set_req(1, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    tick();
    run_burst(0, 1'b1, 24'h123456, 512, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit; the scripted run is far shorter.
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdram_port_sched.md
SDRAM_PORT_SCHED -- requirements
Module: sdram_port_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, meaning user burst start address width {bank,row,col}.
REQ-002 SHALL have parameter BURST_LEN, default 512, meaning expected data beats per burst.
REQ-003 SHALL have parameter WDOG_CYCLES, default 4096, meaning the watchdog limit in WAIT, in clock cycles.
REQ-004 SHALL have port sysclk_100M  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports p0_req/p1_req  in  1  burst request from user port 0/1, held until the matching done.
REQ-007 SHALL have ports p0_wr/p1_wr  in  1  direction: 1 = write, 0 = read.
REQ-008 SHALL have ports p0_addr/p1_addr  in  ADDR_W  burst start address.
REQ-009 SHALL have ports p0_gnt/p1_gnt  out  1  port owns the SDRAM controller.
REQ-010 SHALL have ports p0_done/p1_done  out  1  one-cycle burst-complete pulse.
REQ-011 SHALL have port ctl_write_trig  out  1  one-cycle write start to the SDRAM controller.
REQ-012 SHALL have port ctl_read_trig  out  1  one-cycle read start to the SDRAM controller.
REQ-013 SHALL have port ctl_addr  out  ADDR_W  latched address of the owning port.
REQ-014 SHALL have port ctl_data_vld  in  1  data beat strobe from the controller (write or read).
REQ-015 SHALL have ports ctl_write_end/ctl_read_end  in  1  burst-finished pulses from the controller.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port len_err  out  1  sticky flag: a burst ended with beat count != BURST_LEN.
REQ-018 SHALL have port wdog_err  out  1  sticky watchdog-timeout flag.

Function
REQ-019 SHALL implement FSM IDLE->GRANT->ISSUE->WAIT->DONE->IDLE, one-hot, with registered outputs.
REQ-020 SHALL, in IDLE, select a requester when any pN_req=1: if only one is requesting, select it; if both, select the port not serviced last (round-robin pointer), then go to GRANT.
REQ-021 SHALL, on leaving IDLE, latch owner, wr and addr; later changes on pN_req/pN_wr/pN_addr SHALL be ignored until DONE.
REQ-022 SHALL hold pN_gnt high from GRANT through DONE inclusive; at most one gnt high at any time.
REQ-023 SHALL pulse ctl_write_trig (wr=1) or ctl_read_trig (wr=0) for exactly the ISSUE cycle.
REQ-024 SHALL hold ctl_addr at the latched address from GRANT through DONE.
REQ-025 SHALL count ctl_data_vld beats in ISSUE and WAIT with a counter of clog2(BURST_LEN)+1 bits that saturates at all-ones.
REQ-026 SHALL treat only the end pulse matching the latched direction as completion; the other end pulse SHALL be ignored.
REQ-027 SHALL accept a matching end pulse in ISSUE or WAIT and go to DONE on the next cycle.
REQ-028 SHALL, in DONE, pulse the owner's pN_done, set len_err if beats != BURST_LEN, flip the round-robin pointer, clear the beat counter, and return to IDLE.
REQ-029 SHALL allow a request held high across DONE to be re-arbitrated in the following IDLE cycle (minimum 1 IDLE cycle between bursts).
REQ-030 SHALL give a burst from req rise in IDLE cycle t: gnt at t+1, trig at t+2.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force state=IDLE, round-robin pointer=port 0 preferred, counters=0, and all outputs to 0 (ctl_addr included).
REQ-032 SHALL, on reset mid-burst, abandon the burst without issuing a done; the requester re-requests after reset.

Configuration
REQ-033 SHALL compile the watchdog only when macro SDRAM_SCHED_WDOG_EN is defined.
REQ-034 SHALL, with SDRAM_SCHED_WDOG_EN defined, count cycles in WAIT; on reaching WDOG_CYCLES without a matching end pulse, set wdog_err (sticky until reset) and go to DONE.
REQ-035 SHALL, without SDRAM_SCHED_WDOG_EN, have no watchdog counter, tie wdog_err to 0, and wait indefinitely in WAIT.

Verification
REQ-036 SHALL check: p0_req=1, wr=1, addr=0x000200; controller gives 512 vld then write_end -> gnt0 at t+1, write_trig at t+2, ctl_addr=0x000200, p0_done pulse, len_err=0.
REQ-037 SHALL check: p0_req and p1_req rise together, both held -> order port0, port1, port0, port1; gnt never overlapping.
REQ-038 SHALL check: port1 read with only 500 vld beats before read_end -> p1_done pulse, len_err=1 and it stays 1.
REQ-039 SHALL check: read burst receives write_end, then read_end 10 cycles later -> completion only on read_end.
REQ-040 SHALL check: with SDRAM_SCHED_WDOG_EN defined and WDOG_CYCLES=64, no end pulse -> wdog_err=1 and done exactly 64 cycles into WAIT; without the macro -> remains in WAIT and wdog_err=0.
REQ-041 SHALL check: rst_n low during WAIT -> all outputs 0 immediately, no done pulse, next request serviced normally.
